// File: rtl/din_loader.sv
// din_loader: assembles a WIDTH-bit operand from a stream of WORD-bit words
// (least-significant word first) and presents it with a one-cycle d_in pulse.
// A word carrying in_last before the final word is a framing error: err
// pulses, the partial operand stays visible and the loader returns to IDLE.
module din_loader #(
  parameter int WIDTH = 1506,
  parameter int WORD  = 32,
  parameter int NW    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WORD-1:0]  in_data,
  input  logic             in_last,
  input  logic [7:0]       in_addr,
  output logic             in_ready,
  output logic             d_in,
  output logic [WIDTH-1:0] a_1,
  output logic [7:0]       wr_addr,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_a1;
  logic [7:0]       r_addr;
  logic             r_err;

  logic             w_xfer;
  logic             w_last_word;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_a1_nxt;

  assign w_xfer      = in_valid & in_ready;
  assign w_last_word = (r_cnt == 6'(NW-1));

  // Place the incoming word at slot cnt; bits shifted past WIDTH-1 fall off,
  // which is what clips the top word of the operand.
  assign w_word = WIDTH'(in_data) << (WORD * r_cnt);
  assign w_mask = WIDTH'({WORD{1'b1}}) << (WORD * r_cnt);

  // Word 0 starts a fresh operand (cnt is 0 in IDLE, so w_word holds only word 0)
  always_comb begin
    w_a1_nxt = (r_a1 & ~w_mask) | w_word;
    if (r_state == IDLE) w_a1_nxt = w_word;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: the final word always completes, an early in_last aborts
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, LOAD: begin
        if (w_xfer) begin
          if (w_last_word)  w_next = DONE;
          else if (in_last) w_next = IDLE;
          else              w_next = LOAD;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; in_ready is held low while reset is asserted
  always_comb begin
    in_ready = 1'b0;
    d_in     = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE: in_ready = rst_n;
      LOAD: begin
        in_ready = rst_n;
        busy     = 1'b1;
      end
      DONE: begin
        d_in = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand assembly, address capture, word counter, error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a1   <= '0;
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_xfer) begin
        r_a1 <= w_a1_nxt;
        if (r_state == IDLE) r_addr <= in_addr;
        if (w_last_word) begin
          r_cnt <= '0;
        end else if (in_last) begin
          r_cnt <= '0;
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 6'd1;
        end
      end
    end
  end

  assign a_1     = r_a1;
  assign wr_addr = r_addr;
  assign err     = r_err;

endmodule

// File: tb/tb_din_loader.sv
// Bench for din_loader: directed operands, expected events queued by the
// stimulus and checked by an independent output monitor.
module tb_din_loader;
  localparam int WIDTH = 1506;
  localparam int WORD  = 32;
  localparam int NW    = 48;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WORD-1:0]  in_data;
  logic             in_last;
  logic [7:0]       in_addr;
  logic             in_ready;
  logic             d_in;
  logic [WIDTH-1:0] a_1;
  logic [7:0]       wr_addr;
  logic             busy;
  logic             err;

  din_loader #(.WIDTH(WIDTH), .WORD(WORD), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_addr(in_addr), .in_ready(in_ready), .d_in(d_in),
    .a_1(a_1), .wr_addr(wr_addr), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_err;
    logic [WIDTH-1:0] a1;
    logic [7:0]       addr;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   xfer_cyc;
  int   nrdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic chk_a1(input string nm, input logic [WIDTH-1:0] want);
    int first = -1;
    n_tests++;
    if (a_1 !== want) begin
      for (int b = WIDTH-1; b >= 0; b--) if (a_1[b] !== want[b]) first = b;
      n_fail++;
      $display("FAIL %s: a_1 differs first at bit %0d (got %b want %b)", nm, first, a_1[first], want[first]);
    end
  endtask

  // Output monitor: every d_in / err pulse must match the next queued event
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (d_in === 1'b1 || err === 1'b1)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got d_in=%b err=%b want none", d_in, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind", 64'({d_in, err}), e.is_err ? 64'b01 : 64'b10);
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        if (!e.is_err) begin
          chk_a1("operand", e.a1);
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        end
      end
    end
  end

  function automatic logic [31:0] wd(input int k, input int s);
    if (k == NW-1) return 32'hFFFF_FFFF;
    return 32'(k + 1) + 32'(s) * 32'h100;
  endfunction

  // Present one word from a negedge; returns just after the transfer edge
  task automatic xfer(input logic [31:0] d, input logic l, input logic [7:0] a);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_addr = a;
    while (in_ready !== 1'b1 && t < 20) begin
      nrdy++;
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 xfer_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_op(input logic [7:0] a, input int n, input int last_idx,
                         input int seed, input int gap, input bit push);
    logic [WIDTH-1:0] m;
    logic [31:0]      d;
    exp_t             e;
    m = '0;
    for (int k = 0; k < n; k++) begin
      d = wd(k, seed);
      for (int b = 0; b < 32; b++) if (k*32 + b < WIDTH) m[k*32 + b] = d[b];
      xfer(d, k == last_idx, a);
      if (k == n-1 && push) begin
        e.is_err = (n < NW); e.a1 = m; e.addr = a; e.cyc = xfer_cyc;
        q.push_back(e);
      end
      @(negedge clk);
      if (gap > 0 && k < n-1) idle(gap);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_d_in", 64'(d_in), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk_a1("rst_a1", '0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // normal load
    send_op(8'h15, NW, NW-1, 0, 0, 1'b1);
    idle(2);
    chk("norm_lo", 64'(a_1[31:0]), 64'd1);
    chk("norm_w46", 64'(a_1[1503:1472]), 64'd47);
    chk("norm_top", 64'(a_1[1505:1504]), 64'd3);
    chk("norm_addr_hold", 64'(wr_addr), 64'h15);
    chk("norm_busy_idle", 64'(busy), 64'd0);

    // gapped load
    send_op(8'h16, NW, NW-1, 0, 3, 1'b1);
    idle(2);

    // early last on word 10, then a full operand starting at word 0
    send_op(8'h20, 11, 10, 5, 0, 1'b1);
    idle(1);
    chk("early_busy", 64'(busy), 64'd0);
    chk("early_partial", 64'(a_1[351:320]), 64'h50B);
    chk("early_beyond", 64'(a_1[383:352]), 64'd0);
    chk("early_addr", 64'(wr_addr), 64'h20);
    send_op(8'h21, NW, NW-1, 6, 0, 1'b1);
    idle(2);

    // reset after word 20
    send_op(8'h30, 21, -1, 7, 0, 1'b0);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_a1("mid_rst_a1", '0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(60);

    // back-to-back operands, in_valid held high throughout
    nrdy = 0;
    send_op(8'h01, NW, NW-1, 2, 0, 1'b1);
    send_op(8'h02, NW, NW-1, 3, 0, 1'b1);
    chk("b2b_notready_cycles", 64'(nrdy), 64'd1);
    idle(2);

    // missing last
    send_op(8'h40, NW, -1, 4, 0, 1'b1);
    idle(5);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/din_loader.md
DIN_LOADER -- requirements
Module: din_loader

Interface
REQ-001 Parameter: WIDTH, default 1506, operand width in bits.
REQ-002 Parameter: WORD, default 32, input bus width in bits.
REQ-003 Parameter: NW, default 48, words per operand, equal to ceil(WIDTH/WORD).
REQ-004 Port: clk  input  1  sole clock; all state is updated on the rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  input  1  input word present.
REQ-007 Port: in_data  input  WORD  operand word, least-significant word first.
REQ-008 Port: in_last  input  1  marks the final word of an operand.
REQ-009 Port: in_addr  input  8  destination address; sampled with word 0 only.
REQ-010 Port: in_ready  output  1  loader accepts a word this cycle.
REQ-011 Port: d_in  output  1  one-cycle pulse: assembled operand valid; drives the operand-select d_in line.
REQ-012 Port: a_1  output  WIDTH  assembled operand; drives the operand-select a_1 input.
REQ-013 Port: wr_addr  output  8  address captured for the assembled operand.
REQ-014 Port: busy  output  1  high while the FSM is in LOAD or DONE.
REQ-015 Port: err  output  1  one-cycle pulse on a framing error.

Function
REQ-016 A word SHALL transfer only on a rising edge where in_valid and in_ready are both 1.
REQ-017 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-018 in_ready SHALL be 1 in IDLE and LOAD, and 0 in DONE.
REQ-019 IDLE: on a transfer, the FSM SHALL clear the assembly register, write word 0, capture in_addr, set word counter cnt to 1 and go to LOAD.
REQ-020 LOAD: a transfer with cnt = k SHALL write in_data into a_1 bits [WORD*k+WORD-1 : WORD*k], clipped at WIDTH-1, and increment cnt.
REQ-021 Bits of the final word above WIDTH-1 SHALL be discarded; with the defaults, only bits [1:0] of word 47 land, in a_1[1505:1504].
REQ-022 A transfer with cnt = NW-1 SHALL go to DONE whatever the value of in_last.
REQ-023 A transfer with in_last = 1 and cnt < NW-1 (including word 0) SHALL pulse err for one cycle, clear cnt and return to IDLE.
REQ-024 After a framing error (REQ-023), d_in SHALL not pulse, and a_1 SHALL hold the partial data until the next word 0.
REQ-025 DONE SHALL last exactly one cycle: d_in = 1 and wr_addr valid, then the FSM goes to IDLE.
REQ-026 Latency SHALL be 1 cycle from the transfer of the last word to d_in = 1.
REQ-027 a_1 and wr_addr SHALL hold stable from DONE until the next word-0 transfer.
REQ-028 Every input cycle without in_valid SHALL leave the state unchanged; arbitrary gaps are allowed in LOAD.
REQ-029 A minimum of one idle cycle (the DONE cycle) SHALL separate back-to-back operands.
REQ-030 cnt SHALL be 6 bits wide; it never wraps, because it is cleared on entering DONE or IDLE.
REQ-031 busy SHALL be 1 when the state is LOAD or DONE.

Reset
REQ-032 When rst_n = 0, the block SHALL asynchronously force: state IDLE, cnt = 0, a_1 = 0, wr_addr = 0, d_in = 0, err = 0, busy = 0.
REQ-033 When rst_n = 0, in_ready SHALL be 0 while reset is asserted and 1 on the first cycle after release.
REQ-034 A reset asserted mid-LOAD SHALL discard the partial operand, and no d_in pulse SHALL follow.
REQ-035 Reset release SHALL be synchronous to clk by the environment.

Verification
REQ-036 Normal load: 48 back-to-back words, word k = k+1, word 47 = 0xFFFFFFFF with in_last, in_addr = 0x15 -> d_in pulses on the cycle after word 47, a_1[31:0] = 1, a_1[1503:1472] = 47, a_1[1505:1504] = 2'b11, wr_addr = 0x15.
REQ-037 Gapped load: the normal-load stimulus with in_valid low for 3 cycles between every word -> same a_1 as the normal load, and d_in exactly 1 cycle after the final transfer.
REQ-038 Early last: in_last on word 10 -> err pulses once, d_in never pulses, and the next word is accepted as word 0.
REQ-039 Reset mid-load: rst_n low after word 20 -> a_1 = 0 and busy = 0 immediately, and no d_in pulse follows.
REQ-040 Back-to-back operands: two operands (addr 0x01, 0x02) streamed with in_valid held high -> in_ready = 0 for exactly one cycle, two d_in pulses, and correct wr_addr on each.
REQ-041 Missing last: 48 words with in_last = 0 -> d_in still pulses and err stays 0.
